// File: rtl/twos_complement_pkg.sv
// twos_complement_pkg: shared width default and signed-range helpers
// for the two's-complement negator stage.
package twos_complement_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 1 followed by w-1 zeros.
  function automatic logic [63:0] min_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

  // 0 followed by w-1 ones.
  function automatic logic [63:0] max_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

endpackage

// File: rtl/twos_complement_if.sv
// twos_complement_if: operand/result bundle for the negator.
// master drives in_valid/negate/in_data; slave drives out_valid/out_data/ovf/zero.
interface twos_complement_if
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             in_valid;
  logic             negate;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, negate, in_data,
    input  out_valid, out_data, ovf, zero
  );

  modport slave (
    input  in_valid, negate, in_data,
    output out_valid, out_data, ovf, zero
  );

endinterface

// File: rtl/twos_complement_inc.sv
// twos_complement_inc: combinational WIDTH-bit +1 ripple incrementer.
// Ports: a (operand), sum (a+1 mod 2^WIDTH), carry_out (a was all ones).
module twos_complement_inc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  always_comb begin
    logic w_c;
    w_c = 1'b1;
    sum = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ w_c;
      w_c    = a[i] & w_c;
    end
    carry_out = w_c;
  end

endmodule

// File: rtl/twos_complement.sv
// twos_complement: registered negator, out = negate ? (~in + 1) : in, 1-cycle latency.
// Ports: clk, rst_n (async active-low), bus (twos_complement_if.slave).
// Option: TWOS_COMPLEMENT_SAT_EN saturates the most-negative case to max positive.
module twos_complement
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  twos_complement_if.slave bus
);

  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(min_neg(WIDTH));
`ifdef TWOS_COMPLEMENT_SAT_EN
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(max_pos(WIDTH));
`endif

  logic [WIDTH-1:0] w_inv;
  logic [WIDTH-1:0] w_neg;
  logic             w_carry;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_out;
  logic             w_ovf;
  logic             w_zero;

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;
  logic             r_zero;

  assign w_inv = ~bus.in_data;

  twos_complement_inc #(
    .WIDTH(WIDTH)
  ) u_inc (
    .a        (w_inv),
    .sum      (w_neg),
    .carry_out(w_carry)
  );

  assign w_res = bus.negate ? w_neg : bus.in_data;
  assign w_ovf = bus.negate && (bus.in_data == MIN_NEG);

`ifdef TWOS_COMPLEMENT_SAT_EN
  assign w_out = w_ovf ? MAX_POS : w_res;
`else
  assign w_out = w_res;
`endif

  // Negated result is zero exactly when ~in was all ones (carry out);
  // the saturated value is never zero, so this holds after saturation.
  assign w_zero = bus.negate ? w_carry : ~|bus.in_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else begin
      r_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_data <= w_out;
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign bus.out_valid = r_valid;
  assign bus.out_data  = r_data;
  assign bus.ovf       = r_ovf;
  assign bus.zero      = r_zero;

endmodule

// File: tb/tb_twos_complement.sv
// tb_twos_complement: table-driven check of the WIDTH=4 negator,
// plus reset, valid-gating and mid-stream reset sequences.
module tb_twos_complement;

  localparam int W = 4;

  typedef struct {
    logic         neg;
    logic [W-1:0] d;
    logic [W-1:0] ed;
    logic         eo;
    logic         ez;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  int total = 0;
  int bad   = 0;

  vec_t tbl[$];

  twos_complement_if #(.WIDTH(W)) bus ();

  twos_complement #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic ev,
                     input logic [W-1:0] ed,
                     input logic eo, input logic ez);
    total++;
    if ({bus.out_valid, bus.out_data, bus.ovf, bus.zero} !==
        {ev, ed, eo, ez}) begin
      bad++;
      $display("FAIL %s: got v=%0d d=%0d ovf=%0d z=%0d want v=%0d d=%0d ovf=%0d z=%0d",
               nm, bus.out_valid, bus.out_data, bus.ovf, bus.zero,
               ev, ed, eo, ez);
    end
  endtask

  task automatic drive(input logic v, input logic n,
                       input logic [W-1:0] d);
    bus.in_valid = v;
    bus.negate   = n;
    bus.in_data  = d;
  endtask

  initial begin
    vec_t e;
    logic [W-1:0] x;

    for (int i = 0; i < 16; i++) begin
      x    = W'(i);
      e.neg = 1'b1;
      e.d   = x;
      e.ed  = W'(16 - i);
      e.eo  = (i == 8);
      e.ez  = (i == 0);
`ifdef TWOS_COMPLEMENT_SAT_EN
      if (i == 8) e.ed = 4'd7;
`endif
      tbl.push_back(e);
    end
    tbl.push_back('{1'b0, 4'd5, 4'd5, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd8, 4'd8, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'd0, 4'd0, 1'b0, 1'b1});
    tbl.push_back('{1'b1, 4'd1, 4'd15, 1'b0, 1'b0});

    drive(1'b1, 1'b1, 4'd9);
    #1 rst_n = 1'b0;
    #1 chk("rst_pre_edge", 1'b0, 4'd0, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 1'(i), W'(i + 8));
      chk("rst_hold", 1'b0, 4'd0, 1'b0, 1'b0);
    end

    @(negedge clk);
    drive(1'b0, 1'b1, 4'd3);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_novalid", 1'b0, 4'd0, 1'b0, 1'b0);

    foreach (tbl[k]) begin
      drive(1'b1, tbl[k].neg, tbl[k].d);
      @(negedge clk);
      chk($sformatf("vec%0d_n%0d_d%0d", k, tbl[k].neg, tbl[k].d),
          1'b1, tbl[k].ed, tbl[k].eo, tbl[k].ez);
    end

    drive(1'b1, 1'b1, 4'd3);
    @(negedge clk);
    chk("gate_on", 1'b1, 4'd13, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd6);
    @(negedge clk);
    chk("gate_off", 1'b0, 4'd13, 1'b0, 1'b0);
    @(negedge clk);
    chk("gate_hold", 1'b0, 4'd13, 1'b0, 1'b0);

    drive(1'b1, 1'b1, 4'd1);
    @(negedge clk);
    chk("mid_s1", 1'b1, 4'd15, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd2);
    @(posedge clk);
    #1 chk("mid_s2", 1'b1, 4'd14, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1 chk("mid_async_clr", 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_low", 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 4'd3);
    @(negedge clk);
    chk("mid_s3", 1'b1, 4'd13, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 4'd8);
    @(negedge clk);
`ifdef TWOS_COMPLEMENT_SAT_EN
    chk("mid_min", 1'b1, 4'd7, 1'b1, 1'b0);
`else
    chk("mid_min", 1'b1, 4'd8, 1'b1, 1'b0);
`endif
    drive(1'b1, 1'b1, 4'd0);
    @(negedge clk);
    chk("mid_zero", 1'b1, 4'd0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
